// File: rtl/mem_io_responder_if.sv
// mem_io_responder_if: byte-wide memory bus between the CPU memory controller (master) and the responder (slave)
interface mem_io_responder_if;
  logic [31:0] mem_a;
  logic [7:0]  mem_dout;
  logic        mem_wr;
  logic [7:0]  mem_din;
  logic        io_buffer_full;
  modport master (output mem_a, mem_dout, mem_wr, input mem_din, io_buffer_full);
  modport slave  (input mem_a, mem_dout, mem_wr, output mem_din, io_buffer_full);
endinterface

// File: rtl/mem_io_responder.sv
// mem_io_responder: byte RAM plus I/O window (TX FIFO, halt register); UART transmitter built only when MEM_IO_UART_EN is defined
module mem_io_responder #(
  parameter int ADDR_W          = 17,
  parameter int FIFO_DEPTH_LOG2 = 3,
  parameter int BAUD_DIV        = 868,
  parameter int FULL_MARGIN     = 2
) (
  input  logic                clk_in,
  input  logic                rst_in,
  mem_io_responder_if.slave   bus,
  output logic                uart_tx,
  output logic                tx_byte_valid,
  output logic [7:0]          tx_byte,
  output logic                sim_halt
);
  localparam int L     = FIFO_DEPTH_LOG2;
  localparam int DEPTH = 1 << L;
  logic [7:0] ram [2**ADDR_W];
  logic [7:0] fifo_q [DEPTH];
  logic [L:0] wp_q, rp_q, wp_d, rp_d, cnt_d;
  logic       io_sel, wr_data, wr_halt, empty, full, push, pop;
  logic       ovf_q, halt_q, full_q, tbv_q;
  logic [7:0] din_q, tb_q, rd_io;
  logic       unused_ok;
  assign unused_ok = ^{bus.mem_a[31:18], 1'(BAUD_DIV)};
  assign io_sel  = bus.mem_a[17:16] == 2'b11;
  assign wr_data = bus.mem_wr && io_sel && bus.mem_a[15:0] == 16'h0000;
  assign wr_halt = bus.mem_wr && io_sel && bus.mem_a[15:0] == 16'h0004;
  assign empty   = wp_q == rp_q;
  assign full    = (wp_q[L] != rp_q[L]) && (wp_q[L-1:0] == rp_q[L-1:0]);
  assign push    = wr_data && (!full || pop);
  assign wp_d    = push ? wp_q + 1'b1 : wp_q;
  assign rp_d    = pop ? rp_q + 1'b1 : rp_q;
  assign cnt_d   = wp_d - rp_d;
  assign rd_io   = bus.mem_a[15:0] == 16'h0004 ? {5'b0, ovf_q, empty, full} : 8'h00;
  // Storage arrays carry no reset; FIFO contents are discarded through the pointers
  always_ff @(posedge clk_in) begin
    if (bus.mem_wr && !io_sel) ram[bus.mem_a[ADDR_W-1:0]] <= bus.mem_dout;
    if (push) fifo_q[wp_q[L-1:0]] <= bus.mem_dout;
  end
  // Read data, FIFO pointers, nearly-full flag, sticky flags and the pop strobe
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      din_q  <= 8'h00;
      wp_q   <= '0;
      rp_q   <= '0;
      full_q <= 1'b0;
      ovf_q  <= 1'b0;
      halt_q <= 1'b0;
      tbv_q  <= 1'b0;
      tb_q   <= 8'h00;
    end else begin
      if (!bus.mem_wr) din_q <= io_sel ? rd_io : ram[bus.mem_a[ADDR_W-1:0]];
      wp_q   <= wp_d;
      rp_q   <= rp_d;
      full_q <= (DEPTH - int'(cnt_d)) <= FULL_MARGIN;
      ovf_q  <= ovf_q | (wr_data && full && !pop);
      halt_q <= halt_q | wr_halt;
      tbv_q  <= pop;
      if (pop) tb_q <= fifo_q[rp_q[L-1:0]];
    end
  end
`ifdef MEM_IO_UART_EN
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
  state_t      state_q, state_d;
  logic [15:0] bc_q, bc_d;
  logic [2:0]  bit_q, bit_d;
  logic [7:0]  sh_q, sh_d;
  logic        tx_q, tx_d, bit_end;
  assign bit_end = bc_q == 16'(BAUD_DIV - 1);
  assign pop     = !empty && (state_q == IDLE || (state_q == STOP && bit_end));
  assign uart_tx = tx_q;
  // Frame sequencing; a pop at the end of STOP chains frames with no idle gap
  always_comb begin
    state_d = state_q;
    bc_d    = bit_end ? 16'd0 : bc_q + 16'd1;
    bit_d   = bit_q;
    sh_d    = sh_q;
    tx_d    = tx_q;
    case (state_q)
      IDLE:  bc_d = 16'd0;
      START: if (bit_end) begin
        state_d = DATA;
        bit_d   = 3'd0;
        tx_d    = sh_q[0];
      end
      DATA:  if (bit_end) begin
        if (bit_q == 3'd7) begin
          state_d = STOP;
          tx_d    = 1'b1;
        end else begin
          bit_d = bit_q + 3'd1;
          sh_d  = sh_q >> 1;
          tx_d  = sh_q[1];
        end
      end
      STOP:  if (bit_end) state_d = IDLE;
    endcase
    if (pop) begin
      state_d = START;
      bc_d    = 16'd0;
      sh_d    = fifo_q[rp_q[L-1:0]];
      tx_d    = 1'b0;
    end
  end
  // Transmitter state register; line returns high asynchronously on reset
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_q <= IDLE;
      bc_q    <= 16'd0;
      bit_q   <= 3'd0;
      sh_q    <= 8'h00;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      bc_q    <= bc_d;
      bit_q   <= bit_d;
      sh_q    <= sh_d;
      tx_q    <= tx_d;
    end
  end
`else
  assign pop     = !empty;
  assign uart_tx = 1'b1;
`endif
  assign bus.mem_din        = din_q;
  assign bus.io_buffer_full = full_q;
  assign tx_byte_valid      = tbv_q;
  assign tx_byte            = tb_q;
  assign sim_halt           = halt_q;
endmodule

// File: tb/tb_mem_io_responder.sv
// tb_mem_io_responder: directed self-checking bench for mem_io_responder (both MEM_IO_UART_EN builds)
module tb_mem_io_responder;
  logic clk_in = 1'b0;
  logic rst_in = 1'b0;
  logic uart_tx, tx_byte_valid, sim_halt;
  logic [7:0] tx_byte;
  int n_vec = 0;
  int n_bad = 0;
  mem_io_responder_if bus();
  mem_io_responder #(.ADDR_W(17), .FIFO_DEPTH_LOG2(3), .BAUD_DIV(4), .FULL_MARGIN(2)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .bus(bus), .uart_tx(uart_tx),
    .tx_byte_valid(tx_byte_valid), .tx_byte(tx_byte), .sim_halt(sim_halt)
  );
  always #5 clk_in = ~clk_in;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask
  task automatic wr(input logic [31:0] a, input logic [7:0] d);
    bus.mem_a = a;
    bus.mem_dout = d;
    bus.mem_wr = 1'b1;
    tick();
    bus.mem_wr = 1'b0;
  endtask
  task automatic rd(input logic [31:0] a);
    bus.mem_a = a;
    bus.mem_wr = 1'b0;
    tick();
  endtask
  task automatic do_reset();
    rst_in = 1'b0;
    tick();
    tick();
    #2 rst_in = 1'b1;
    tick();
  endtask
  logic [7:0] burst [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
  logic [9:0] frame = 10'b1_0101_0101_0;
  initial begin
    bus.mem_a = 32'h0;
    bus.mem_dout = 8'h0;
    bus.mem_wr = 1'b0;
    tick();
    tick();
    chk("rst_din", bus.mem_din, 8'h00);
    chk("rst_full", bus.io_buffer_full, 1'b0);
    chk("rst_tx", uart_tx, 1'b1);
    chk("rst_vld", tx_byte_valid, 1'b0);
    chk("rst_byte", tx_byte, 8'h00);
    chk("rst_halt", sim_halt, 1'b0);
    #2 rst_in = 1'b1;
    tick();
    wr(32'h10, 8'hA5);
    rd(32'h10);
    chk("ram_rd", bus.mem_din, 8'hA5);
    rd(32'h30000);
    chk("io_data_rd", bus.mem_din, 8'h00);
    rd(32'h30004);
    chk("io_stat_idle", bus.mem_din, 8'h02);
    rd(32'h30008);
    chk("io_other_rd", bus.mem_din, 8'h00);
    for (int i = 0; i < 4; i++) wr(32'h100 + i, burst[i]);
    for (int i = 0; i < 4; i++) begin
      rd(32'h100 + i);
      chk($sformatf("burst%0d", i), bus.mem_din, burst[i]);
    end
    wr(32'h200, 8'h99);
    chk("wr_holds_din", bus.mem_din, 8'h44);
    rd(32'h200);
    chk("ram_rd2", bus.mem_din, 8'h99);
    wr(32'h30000, 8'h55);
    chk("tx_pre_idle", uart_tx, 1'b1);
    tick();
    chk("tx_vld", tx_byte_valid, 1'b1);
    chk("tx_byte", tx_byte, 8'h55);
`ifdef MEM_IO_UART_EN
    for (int b = 0; b < 10; b++)
      for (int k = 0; k < 4; k++) begin
        chk($sformatf("uart_b%0d_c%0d", b, k), uart_tx, frame[b]);
        if (b == 0 && k == 1) chk("tx_vld_strobe", tx_byte_valid, 1'b0);
        tick();
      end
    chk("uart_idle_after", uart_tx, 1'b1);
`else
    tick();
    chk("tx_vld_strobe", tx_byte_valid, 1'b0);
    chk("uart_tied", uart_tx, 1'b1);
`endif
    do_reset();
    force dut.pop = 1'b0;
    for (int i = 0; i < 6; i++) begin
      wr(32'h30000, 8'h60 + 8'(i));
      if (i == 4) chk("full_after5", bus.io_buffer_full, 1'b0);
    end
    chk("full_after6", bus.io_buffer_full, 1'b1);
    for (int i = 6; i < 9; i++) wr(32'h30000, 8'h60 + 8'(i));
    rd(32'h30004);
    chk("stat_ovf", bus.mem_din, 8'h05);
    chk("full_held", bus.io_buffer_full, 1'b1);
    release dut.pop;
    begin
      int k = 0;
      while (!tx_byte_valid && k < 400) begin
        tick();
        k++;
      end
    end
    chk("drain_vld", tx_byte_valid, 1'b1);
    chk("drain_first", tx_byte, 8'h60);
    do_reset();
    wr(32'h30004, 8'h00);
    chk("halt_set", sim_halt, 1'b1);
    wr(32'h30000, 8'h00);
    wr(32'h30000, 8'h00);
    for (int i = 0; i < 5; i++) tick();
    chk("halt_sticky", sim_halt, 1'b1);
`ifdef MEM_IO_UART_EN
    chk("mid_frame_low", uart_tx, 1'b0);
`endif
    rst_in = 1'b0;
    #1;
    chk("mid_rst_tx", uart_tx, 1'b1);
    chk("mid_rst_halt", sim_halt, 1'b0);
    chk("mid_rst_empty", dut.empty, 1'b1);
    chk("mid_rst_full", bus.io_buffer_full, 1'b0);
    tick();
    #2 rst_in = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    chk("post_rst_novld", tx_byte_valid, 1'b0);
    chk("post_rst_tx", uart_tx, 1'b1);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
